// File: rtl/codificador_pkg.sv
// Shared types and helpers for the keypad priority encoder: FSM state encoding
// and the highest-set-bit priority function.
package codificador_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRANDO   = 2'd1,
        PRESSIONADO = 2'd2
    } estado_t;

    localparam int MAX_ENTRADAS = 64;

    // Highest index wins; an all-zero vector returns 0 (callers gate on "any key").
    function automatic int prioridade_idx(input logic [MAX_ENTRADAS-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < MAX_ENTRADAS; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/codificador_prioritario_teclado_if.sv
// Event channel from the keypad encoder to the timer controller.
// valido/ack: an event is offered while valido=1 and is consumed at the first
// rising edge where ack=1; codigo and multipla stay frozen while valido=1,
// and ack while valido=0 has no effect.
interface codificador_prioritario_teclado_if #(
    parameter int LARGURA_CODIGO = 4
);
    logic [LARGURA_CODIGO-1:0] codigo;
    logic                      valido;
    logic                      ack;
    logic                      multipla;
    logic                      perda;

    modport master (
        output codigo,
        output valido,
        output multipla,
        output perda,
        input  ack
    );

    modport slave (
        input  codigo,
        input  valido,
        input  multipla,
        input  perda,
        output ack
    );
endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a vector of asynchronous lines; resets to zero.
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [LARGURA-1:0] d,
    output logic [LARGURA-1:0] q
);

    logic [LARGURA-1:0] meta;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/codificador_prioritario_teclado.sv
// Debounced keypad priority encoder with a valid/ack event output.
// Optional auto-repeat while a key is held: define CODIFICADOR_REPETICAO_EN.
module codificador_prioritario_teclado
    import codificador_pkg::*;
#(
    parameter int N_ENTRADAS       = 10,
    parameter int LARGURA_CODIGO   = $clog2(N_ENTRADAS),
    parameter int CICLOS_FILTRO    = 16,
    parameter int CICLOS_REPETICAO = 1000
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic                                   enablen,
    input  logic [N_ENTRADAS-1:0]                  entrada,
    codificador_prioritario_teclado_if.master      bus,
    output estado_t                                estado_dbg
);

    if (N_ENTRADAS < 2 || N_ENTRADAS > MAX_ENTRADAS || CICLOS_FILTRO < 1 ||
        CICLOS_REPETICAO < 1) begin : g_parametros_invalidos
        $error("codificador_prioritario_teclado: invalid parameter set");
    end

    localparam int LARGURA_CNT = (CICLOS_FILTRO > 1) ? $clog2(CICLOS_FILTRO) : 1;
    localparam logic [LARGURA_CNT-1:0] FIM_FILTRO = LARGURA_CNT'(CICLOS_FILTRO - 1);
    localparam logic [LARGURA_CNT-1:0] UM_CNT     = LARGURA_CNT'(1);
    localparam logic [N_ENTRADAS-1:0]  UM_S       = N_ENTRADAS'(1);

    logic [N_ENTRADAS-1:0]     s;
    logic [LARGURA_CODIGO-1:0] idx;
    logic                      alguma;
    logic                      mesma_tecla;
    logic                      multi;
    logic                      fim_filtro;
    logic                      rep_fim;
    logic                      captura;

    estado_t                   estado;
    logic [LARGURA_CODIGO-1:0] cand;
    logic [LARGURA_CNT-1:0]    cnt;
    logic [LARGURA_CODIGO-1:0] codigo_q;
    logic                      valido_q;
    logic                      multipla_q;
    logic                      perda_q;

    sincronizador_2ff #(
        .LARGURA (N_ENTRADAS)
    ) u_sinc (
        .clock  (clock),
        .resetn (resetn),
        .d      (entrada),
        .q      (s)
    );

    assign idx         = LARGURA_CODIGO'(prioridade_idx(64'(s)));
    assign alguma      = |s;
    assign mesma_tecla = alguma && (idx == cand);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi       = |(s & (s - UM_S));
    assign fim_filtro  = (estado == FILTRANDO) && mesma_tecla && (cnt == FIM_FILTRO);
    assign captura     = !enablen && (fim_filtro || rep_fim);

`ifdef CODIFICADOR_REPETICAO_EN
    localparam int LARGURA_REP = (CICLOS_REPETICAO > 1) ? $clog2(CICLOS_REPETICAO) : 1;
    localparam logic [LARGURA_REP-1:0] FIM_REP = LARGURA_REP'(CICLOS_REPETICAO - 1);
    localparam logic [LARGURA_REP-1:0] UM_REP  = LARGURA_REP'(1);

    logic [LARGURA_REP-1:0] rep;
    logic                   repetindo;

    // The original key must still be the winner; any other key restarts the hold.
    assign repetindo = !enablen && (estado == PRESSIONADO) && mesma_tecla;
    assign rep_fim   = repetindo && (rep == FIM_REP);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rep <= '0;
        end else if (!repetindo || rep_fim) begin
            rep <= '0;
        end else begin
            rep <= rep + UM_REP;
        end
    end
`else
    assign rep_fim = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            estado     <= OCIOSO;
            cand       <= '0;
            cnt        <= '0;
            codigo_q   <= '0;
            valido_q   <= 1'b0;
            multipla_q <= 1'b0;
            perda_q    <= 1'b0;
        end else begin
            perda_q <= 1'b0;

            // A capture coinciding with ack replaces the consumed event in place.
            if (captura) begin
                if (!valido_q || bus.ack) begin
                    codigo_q   <= cand;
                    multipla_q <= multi;
                    valido_q   <= 1'b1;
                end else begin
                    perda_q <= 1'b1;
                end
            end else if (valido_q && bus.ack) begin
                valido_q <= 1'b0;
            end

            if (enablen) begin
                estado <= OCIOSO;
                cnt    <= '0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (alguma) begin
                            estado <= FILTRANDO;
                            cand   <= idx;
                            cnt    <= '0;
                        end
                    end
                    FILTRANDO: begin
                        if (!mesma_tecla) begin
                            estado <= OCIOSO;
                        end else if (cnt == FIM_FILTRO) begin
                            estado <= PRESSIONADO;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + UM_CNT;
                        end
                    end
                    PRESSIONADO: begin
                        // cnt now counts consecutive all-released cycles.
                        if (alguma) begin
                            cnt <= '0;
                        end else if (cnt == FIM_FILTRO) begin
                            estado <= OCIOSO;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + UM_CNT;
                        end
                    end
                    default: begin
                        estado <= OCIOSO;
                        cnt    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.codigo   = codigo_q;
    assign bus.valido   = valido_q;
    assign bus.multipla = multipla_q;
    assign bus.perda    = perda_q;
    assign estado_dbg   = estado;

endmodule

// File: doc/codificador_prioritario_teclado.md
Name: codificador_prioritario_teclado

Overview:
Parametrised, clocked successor to the combinational one-hot-to-BCD priority encoder in the timer/control path. It takes N key lines, synchronises and debounces them, and resolves simultaneous presses by true priority (highest index wins). Each accepted press is held as a binary/BCD code with a valid/ack handshake toward the timer controller. Sits between the keypad inputs and the timer-setting FSM.

Parameters:
N_ENTRADAS, 10, number of key lines; legal range 2..64.
LARGURA_CODIGO, $clog2(N_ENTRADAS), width of codigo; for N_ENTRADAS=10 the code is BCD 0..9.
CICLOS_FILTRO, 16, consecutive stable cycles needed to accept a press and to accept a release; minimum 1.
CICLOS_REPETICAO, 1000, hold cycles per auto-repeat event; used only with the optional feature.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
enablen  in  1  active-low detection enable.
entrada  in  N_ENTRADAS  raw asynchronous key lines, active high.
codigo  out  LARGURA_CODIGO  index of the accepted key.
valido  out  1  codigo holds an unacknowledged event.
ack  in  1  consumer acknowledge.
multipla  out  1  more than one line was high at the capture edge; valid alongside codigo.
perda  out  1  one-cycle pulse when an event is dropped because valido was still pending.

Behaviour:
- Reset (async assert; release is synchronous to clock): codigo=0, valido=0, multipla=0, perda=0, FSM=OCIOSO, sync flops=0, counters=0.
- Sync: each entrada bit passes through 2 flops. All further logic uses the synchronised vector s.
- Priority: idx = highest set bit of s. "nenhuma" means s==0.
- FSM OCIOSO: if enablen=0 and s!=0, go to FILTRANDO, load cand=idx, cnt=0.
- FSM FILTRANDO: if s==0 or idx!=cand, go to OCIOSO. Otherwise, if cnt==CICLOS_FILTRO-1, perform a capture and go to PRESSIONADO. Otherwise cnt++.
- FSM PRESSIONADO: waits for release. s==0 for CICLOS_FILTRO consecutive cycles returns to OCIOSO. Any nonzero cycle restarts the release count. Changing to a different key while in PRESSIONADO is ignored.
- Capture: if valido=0, or ack=1 in the same cycle, load codigo=cand, multipla=(popcount(s)>1), valido=1. Otherwise drop the event, pulse perda for 1 cycle, and leave codigo unchanged.
- Latency: with entrada stable from edge 0, valido is high after edge CICLOS_FILTRO+3 (2 sync edges, 1 entry edge, CICLOS_FILTRO filter edges).
- Handshake: valido stays high until ack=1 is sampled at an edge; valido=0 after that edge. ack while valido=0 is ignored. ack and capture on the same edge: the new event wins, valido stays 1, no perda. codigo and multipla are held while valido=1.
- enablen=1: FSM is forced to OCIOSO on the next edge and cnt is cleared. codigo, valido and the handshake are unaffected. Returning enablen to 0 with a key held restarts filtering from zero.
- Reset mid-press clears all state. After release of reset, a still-held key is filtered anew.

Optional Feature:
Macro CODIFICADOR_REPETICAO_EN.
- Defined: in PRESSIONADO with the same idx held, a repeat counter counts to CICLOS_REPETICAO-1, then performs a capture (same drop/perda rules) and restarts. The counter clears on any change of idx or on exit from PRESSIONADO.
- Undefined: exactly one event per press; no repeat counter is synthesised.

Decomposition:
- Package codificador_pkg: state enum (OCIOSO, FILTRANDO, PRESSIONADO) and the function prioridade_idx(vector) returning the highest set index.
- One sub-module, sincronizador_2ff: parametrised width, clock and resetn ports, reset value 0.

Test Plan:
1. N=10, F=4: entrada=10'b0000100000 held 20 cycles -> valido high at edge 7, codigo=4'b0101, multipla=0. After ack, valido=0. A single event only.
2. entrada=10'b1000000100 -> codigo=4'b1001, multipla=1.
3. Glitch: bit3 high for 3 cycles, then low -> no valido. Bit3 bouncing 1-0-1 before stabilising -> exactly one event, codigo=3.
4. Event pending without ack, then a second press of key 7 -> perda pulses 1 cycle, codigo keeps the first value. Repeat with ack asserted on the capture edge -> codigo=7, valido stays 1, perda=0.
5. enablen=1 during FILTRANDO -> no event. resetn pulse low while valido=1 -> codigo=0, valido=0 immediately, without waiting for a clock edge.
6. With CODIFICADOR_REPETICAO_EN, CICLOS_REPETICAO=10, ack tied high: key 2 held 45 cycles past capture -> 1+4 events, each codigo=2.
